// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, frame width and baud-divider helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_TX_IDLE,
    UART_TX_START,
    UART_TX_DATA,
    UART_TX_STOP
  } uart_tx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

  // Clock cycles per bit; truncating, legal when the result is at least 2.
  function automatic int unsigned uart_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int unsigned uart_div_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sync_fifo_8.sv
// Single-clock byte FIFO with show-ahead read data, occupancy count and full/empty flags.
module sync_fifo_8 #(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [7:0]       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  // Pushes into a full FIFO and pops from an empty one are dropped.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO drained by a baud-timed start/data/stop shifter.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 12000000,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned Div  = uart_div(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned DivW = uart_div_width(Div);
  localparam int unsigned BitW = $clog2(UART_DATA_BITS);
  localparam logic [DivW-1:0] BaudMax = DivW'(Div - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(UART_DATA_BITS - 1);

  uart_tx_state_e state_q, state_d;
  logic [DivW-1:0] baud_q, baud_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       bit_end;

  assign fifo_push = in_valid && in_ready;
  assign in_ready  = !fifo_full;

  sync_fifo_8 #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bit_end = (baud_q == BaudMax);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    // Counter restarts at every bit boundary so bit lengths never accumulate error.
    baud_d   = (state_q == UART_TX_IDLE || bit_end) ? '0 : baud_q + 1'b1;

    unique case (state_q)
      UART_TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = UART_TX_START;
        end
      end
      UART_TX_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = UART_TX_DATA;
        end
      end
      UART_TX_DATA: begin
        if (bit_end) begin
          if (bit_q == BitLast) begin
            state_d = UART_TX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      UART_TX_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = UART_TX_START;
          end else begin
            state_d = UART_TX_IDLE;
          end
        end
      end
      default: state_d = UART_TX_IDLE;
    endcase

    // Line level follows the state being entered, so txd is a clean register output.
    case (state_d)
      UART_TX_START: txd_d = 1'b0;
      UART_TX_DATA:  txd_d = shift_d[bit_d];
      default:       txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != UART_TX_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: line decoder, frame tables and a timing reference model.
module tb_uart_tx_buffered;

  localparam int unsigned Depth = 4;
  localparam int          Div   = 16;
  localparam int          Frame = 10 * Div;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, txd, busy;
  logic [2:0] fifo_count;

  uart_tx_buffered #(
    .CLOCK_FREQ (160),
    .BAUD_RATE  (10),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit k = level expected at the centre of bit slot k
  } vec_t;
  vec_t vecs[6];

  logic [7:0] rx_byte[$];
  int         rx_start[$];
  bit         rx_ok[$];
  logic [7:0] exp_byte[$];
  int         exp_start[$];
  bit         mon_en = 1'b1;
  bit         mon_busy = 1'b0;

  int acc_t[$];
  int st_t[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_rx();
    rx_byte.delete();
    rx_start.delete();
    rx_ok.delete();
    exp_byte.delete();
    exp_start.delete();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((busy !== 1'b0 || mon_busy) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_in_time", (n < max_cyc), 1);
    repeat (2) step();
  endtask

  task automatic check_rx(input string name);
    check({name, "_frames"}, rx_byte.size(), exp_byte.size());
    for (int i = 0; i < exp_byte.size() && i < rx_byte.size(); i++) begin
      check({name, "_byte"}, rx_byte[i], exp_byte[i]);
      check({name, "_framing"}, rx_ok[i], 1);
      if (exp_start[i] >= 0) check({name, "_start_cycle"}, rx_start[i], exp_start[i]);
    end
  endtask

  // Reference model: bytes queued = accepted so far minus frames started so far.
  function automatic int model_count(input int t);
    int n;
    n = 0;
    foreach (acc_t[i]) if (acc_t[i] <= t) n++;
    foreach (st_t[i]) if (st_t[i] <= t) n--;
    return n;
  endfunction

  function automatic bit model_on_line(input int t);
    foreach (st_t[i]) if (st_t[i] <= t && t < st_t[i] + Frame) return 1'b1;
    return 1'b0;
  endfunction

  // Line decoder: finds a falling start edge, samples each bit slot at its centre.
  initial begin
    int         s;
    bit         ok;
    logic [7:0] b;
    forever begin
      step();
      if (mon_en && rst_n && txd === 1'b0) begin
        s = cyc;
        mon_busy = 1'b1;
        ok = 1'b1;
        repeat (Div / 2) step();
        if (txd !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (Div) step();
          b[k] = txd;
        end
        repeat (Div) step();
        if (txd !== 1'b1) ok = 1'b0;
        rx_byte.push_back(b);
        rx_start.push_back(s);
        rx_ok.push_back(ok);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] got;
    logic [7:0] six[6];
    int         t0;
    int         last_start;
    int         pv;
    int         mc;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h55, 10'b1010101010};
    vecs[4] = '{8'h3C, 10'b1001111000};
    vecs[5] = '{8'h81, 10'b1100000010};
    six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset, then 100 idle cycles.
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_after_reset", {txd, busy, in_ready, fifo_count}, 6'b101000);
    end

    // Single frames from the table, sampled at bit centres.
    for (int v = 0; v < 6; v++) begin
      in_data  = vecs[v].data;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("line_high_at_push", txd, 1);
      check("count_after_push", fifo_count, 1);
      step();
      check("start_low_after_pop", txd, 0);
      check("count_after_pop", fifo_count, 0);
      repeat (Div / 2) step();
      got[0] = txd;
      for (int k = 1; k < 10; k++) begin
        repeat (Div) step();
        got[k] = txd;
      end
      check("frame_line", got, vecs[v].line);
      repeat (Div / 2 - 1) step();
      check("busy_in_stop", busy, 1);
      step();
      check("idle_after_frame", {busy, txd}, 2'b01);
      repeat (3) step();
    end

    // Three bytes on consecutive cycles: frames back to back.
    clear_rx();
    in_valid = 1'b1;
    in_data  = 8'h00;
    step();
    t0 = cyc;
    check("b2b_count0", fifo_count, 1);
    in_data = 8'hFF;
    step();
    check("b2b_count1", fifo_count, 1);
    in_data = 8'h55;
    step();
    in_valid = 1'b0;
    check("b2b_count2", fifo_count, 2);
    repeat (Frame - 2) step();
    check("b2b_count_before_pop", fifo_count, 2);
    step();
    check("b2b_count_after_pop", fifo_count, 1);
    repeat (Frame) step();
    check("b2b_count_drained", fifo_count, 0);
    wait_idle(400);
    exp_byte  = '{8'h00, 8'hFF, 8'h55};
    exp_start = '{t0 + 1, t0 + 1 + Frame, t0 + 1 + 2 * Frame};
    check_rx("b2b");

    // Push and pop on the same edge with two bytes queued.
    clear_rx();
    in_valid = 1'b1;
    in_data  = 8'hA1;
    step();
    t0 = cyc;
    in_data = 8'hB2;
    step();
    in_data = 8'hC3;
    step();
    in_valid = 1'b0;
    check("pp_count_setup", fifo_count, 2);
    repeat (Frame - 2) step();
    check("pp_count_before", fifo_count, 2);
    in_valid = 1'b1;
    in_data  = 8'hD4;
    step();
    in_valid = 1'b0;
    check("pp_count_same_edge", fifo_count, 2);
    wait_idle(800);
    exp_byte  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp_start = '{t0 + 1, t0 + 1 + Frame, t0 + 1 + 2 * Frame, t0 + 1 + 3 * Frame};
    check_rx("pushpop");

    // Six bytes with in_valid held: FIFO fills, sixth waits for a free entry.
    clear_rx();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = six[i];
      step();
      if (i == 0) t0 = cyc;
    end
    check("hold_full", {in_ready, fifo_count}, {1'b0, 3'd4});
    in_data = six[5];
    repeat (Frame - 4) step();
    check("hold_still_full", {in_ready, fifo_count}, {1'b0, 3'd4});
    step();
    check("hold_entry_freed", {in_ready, fifo_count}, {1'b1, 3'd3});
    step();
    in_valid = 1'b0;
    check("hold_refilled", {in_ready, fifo_count}, {1'b0, 3'd4});
    wait_idle(1200);
    for (int i = 0; i < 6; i++) begin
      exp_byte.push_back(six[i]);
      exp_start.push_back(t0 + 1 + i * Frame);
    end
    check_rx("hold6");

    // Reset mid-frame (cycle 70 of a 0x3C frame, second byte queued).
    mon_en = 1'b0;
    clear_rx();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_data = 8'hC3;
    step();
    in_valid = 1'b0;
    check("rst_setup_busy", {busy, fifo_count}, {1'b1, 3'd1});
    repeat (70) step();
    #2 rst_n = 1'b0;
    #1 check("rst_async_mid", {txd, busy, in_ready, fifo_count}, 6'b101000);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check("idle_after_rst", {txd, busy, in_ready, fifo_count}, 6'b101000);
    end

    // Reset during the start bit: txd must rise without waiting for a clock edge.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("start_bit_low", txd, 0);
    #2 rst_n = 1'b0;
    #1 check("rst_async_start", txd, 1);
    step();
    rst_n = 1'b1;
    repeat (5) step();

    // Clean frame after reset.
    mon_en = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    t0 = cyc;
    in_valid = 1'b0;
    wait_idle(400);
    exp_byte  = '{8'h3C};
    exp_start = '{t0 + 1};
    check_rx("after_rst");

    // Randomised pushes against the timing reference model.
    clear_rx();
    acc_t.delete();
    st_t.delete();
    last_start = -100000;
    for (int i = 0; i < 3000; i++) begin
      pv = (i < 1200) ? 90 : 15;
      mc = model_count(cyc);
      check("rand_state", {busy, in_ready, fifo_count},
            {(mc != 0) || model_on_line(cyc), (mc != Depth), 3'(mc)});
      in_valid = ($urandom_range(0, 99) < pv);
      in_data  = 8'($urandom);
      if (in_valid && mc != Depth) begin
        acc_t.push_back(cyc + 1);
        last_start = (cyc + 2 > last_start + Frame) ? cyc + 2 : last_start + Frame;
        st_t.push_back(last_start);
        exp_byte.push_back(in_data);
        exp_start.push_back(last_start);
      end
      step();
    end
    in_valid = 1'b0;
    wait_idle((Depth + 2) * Frame);
    check_rx("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
